// File: rtl/bcd_down_counter.sv
// bcd_down_counter: multi-digit BCD countdown counter / programmable interval timer
//   Loads a BCD preset, decrements once per enabled cycle with digit borrow
//   (x0 -> x9) and flags expiry at zero.
//   Optional feature macro: BCD_AUTORELOAD_EN. When it is defined, the counter
//   reloads the last accepted preset on the first enabled cycle after expiry.
//   Ports:
//     Clock  in   rising-edge clock
//     Resetn in   asynchronous active-low reset
//     Load   in   load preset D (priority over E)
//     D      in   preset, digit 0 in D[3:0]
//     E      in   count enable
//     BCD    out  current count, digit 0 in BCD[3:0]
//     Busy   out  1 while counting (state RUN)
//     Zero   out  combinational BCD == 0
//     TC     out  registered 1-cycle pulse when the count reaches 0
//     Err    out  registered 1-cycle pulse when a Load is rejected
module bcd_down_counter #(
    parameter int DIGITS = 2
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  logic                Load,
    input  logic [4*DIGITS-1:0] D,
    input  logic                E,
    output logic [4*DIGITS-1:0] BCD,
    output logic                Busy,
    output logic                Zero,
    output logic                TC,
    output logic                Err
);
    typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;
    localparam logic [4*DIGITS-1:0] one = {{(4*DIGITS-1){1'b0}}, 1'b1};
    state_t state;
    logic [4*DIGITS-1:0] dec;
    logic [DIGITS-1:0] lz, ok;
`ifdef BCD_AUTORELOAD_EN
    logic [4*DIGITS-1:0] reload;
`endif
    // lz[i]: every digit below i is zero, so digit i takes the borrow
    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        if (i == 0) begin : g_lsd
            assign lz[i] = 1'b1;
        end else begin : g_up
            assign lz[i] = lz[i-1] & (BCD[4*i-4 +: 4] == 4'd0);
        end
        assign dec[4*i +: 4] = !lz[i] ? BCD[4*i +: 4] :
                               (BCD[4*i +: 4] == 4'd0) ? 4'd9 : BCD[4*i +: 4] - 4'd1;
        assign ok[i] = D[4*i +: 4] <= 4'd9;
    end
    assign Zero = BCD == '0;
    assign Busy = state == RUN;
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            BCD   <= '0;
            state <= IDLE;
            TC    <= 1'b0;
            Err   <= 1'b0;
`ifdef BCD_AUTORELOAD_EN
            reload <= '0;
`endif
        end else begin
            TC  <= 1'b0;
            Err <= 1'b0;
            if (Load) begin
                if (&ok) begin
                    BCD   <= D;
                    state <= (D == '0) ? EXPIRED : RUN;
`ifdef BCD_AUTORELOAD_EN
                    reload <= D;
`endif
                end else begin
                    Err <= 1'b1;
                end
            end else if (E && state == RUN) begin
                BCD <= dec;
                if (BCD == one) begin
                    state <= EXPIRED;
                    TC    <= 1'b1;
                end
            end
`ifdef BCD_AUTORELOAD_EN
            // a zero reload value would give a zero-length period, so stay expired
            else if (E && state == EXPIRED && reload != '0) begin
                BCD   <= reload;
                state <= RUN;
            end
`endif
        end
    end
endmodule

// File: tb/tb_bcd_down_counter.sv
// tb_bcd_down_counter: table-driven and scoreboard checks for bcd_down_counter
module tb_bcd_down_counter;
    typedef struct {
        logic       load;
        logic [7:0] d;
        logic       e;
        logic [7:0] bcd;
        logic       busy;
        logic       tc;
        logic       err;
    } vec_t;

    logic Clock = 1'b0;
    logic Resetn = 1'b0;
    logic Load = 1'b0, E = 1'b0;
    logic [7:0] D = '0, BCD;
    logic Busy, Zero, TC, Err;
    logic Load3 = 1'b0, E3 = 1'b0;
    logic [11:0] D3 = '0, BCD3;
    logic Busy3, Zero3, TC3, Err3;
    int errors = 0;
    int checks = 0;
    vec_t sb[$];
    vec_t tbl[14];

    always #5 Clock = ~Clock;

    bcd_down_counter #(.DIGITS(2)) dut (
        .Clock(Clock), .Resetn(Resetn), .Load(Load), .D(D), .E(E),
        .BCD(BCD), .Busy(Busy), .Zero(Zero), .TC(TC), .Err(Err)
    );

    bcd_down_counter #(.DIGITS(3)) dut3 (
        .Clock(Clock), .Resetn(Resetn), .Load(Load3), .D(D3), .E(E3),
        .BCD(BCD3), .Busy(Busy3), .Zero(Zero3), .TC(TC3), .Err(Err3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    // drive one cycle, queue the expectation, compare after the edge
    task automatic step(input logic l, input logic [7:0] d, input logic e,
                        input logic [7:0] xb, input logic xbusy, input logic xtc, input logic xerr);
        vec_t v;
        Load = l; D = d; E = e;
        sb.push_back('{l, d, e, xb, xbusy, xtc, xerr});
        @(posedge Clock);
        #1;
        v = sb.pop_front();
        chk("bcd", 32'(BCD), 32'(v.bcd));
        chk("busy", 32'(Busy), 32'(v.busy));
        chk("zero", 32'(Zero), 32'(v.bcd == 8'h00));
        chk("tc", 32'(TC), 32'(v.tc));
        chk("err", 32'(Err), 32'(v.err));
    endtask

    task automatic step3(input logic l, input logic [11:0] d, input logic e, input logic [11:0] xb);
        Load3 = l; D3 = d; E3 = e;
        @(posedge Clock);
        #1;
        chk("bcd3", 32'(BCD3), 32'(xb));
        chk("busy3", 32'(Busy3), 32'(xb != 12'h000));
    endtask

    initial begin
        int cur;
        tbl[0]  = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 8'h3A, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 8'h20, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 8'h19, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 8'h19, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 8'h3A, 1'b1, 8'h19, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 8'h18, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 8'hA5, 1'b0, 8'h18, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 8'h0F, 1'b0, 8'h18, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 8'h17, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 8'h17, 1'b1, 1'b0, 1'b0};

        #12;
        chk("rst_bcd", 32'(BCD), 32'h0);
        chk("rst_busy", 32'(Busy), 32'h0);
        chk("rst_zero", 32'(Zero), 32'h1);
        chk("rst_tc", 32'(TC), 32'h0);
        chk("rst_err", 32'(Err), 32'h0);
        @(negedge Clock);
        Resetn = 1'b1;

        for (int i = 0; i < 14; i++)
            step(tbl[i].load, tbl[i].d, tbl[i].e, tbl[i].bcd, tbl[i].busy, tbl[i].tc, tbl[i].err);

        // count the rest of the way down from 17 to expiry
        for (int n = 16; n >= 1; n--)
            step(1'b0, 8'h00, 1'b1, to_bcd(n), 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
`ifdef BCD_AUTORELOAD_EN
        step(1'b0, 8'h00, 1'b1, 8'h20, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0);
`else
        step(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
`endif

        // load wins over enable
        step(1'b1, 8'h05, 1'b0, 8'h05, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h42, 1'b1, 8'h42, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 8'h41, 1'b1, 1'b0, 1'b0);

        // enable held through expiry
        step(1'b1, 8'h03, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0);
        cur = 3;
        for (int i = 0; i < 12; i++) begin
            logic xtc;
            xtc = 1'b0;
            if (cur > 0) begin
                cur--;
                xtc = cur == 0;
            end else begin
`ifdef BCD_AUTORELOAD_EN
                cur = 3;
`endif
            end
            step(1'b0, 8'h00, 1'b1, to_bcd(cur), cur != 0, xtc, 1'b0);
        end

        // asynchronous reset mid-count
        step(1'b1, 8'h37, 1'b0, 8'h37, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 8'h36, 1'b1, 1'b0, 1'b0);
        E = 1'b0;
        #2;
        Resetn = 1'b0;
        #1;
        chk("arst_bcd", 32'(BCD), 32'h0);
        chk("arst_busy", 32'(Busy), 32'h0);
        chk("arst_zero", 32'(Zero), 32'h1);
        chk("arst_tc", 32'(TC), 32'h0);
        @(negedge Clock);
        Resetn = 1'b1;
        step(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);

        // three-digit borrow chains
        step3(1'b1, 12'h100, 1'b0, 12'h100);
        step3(1'b0, 12'h000, 1'b1, 12'h099);
        step3(1'b0, 12'h000, 1'b1, 12'h098);
        step3(1'b1, 12'h010, 1'b0, 12'h010);
        step3(1'b0, 12'h000, 1'b1, 12'h009);
        step3(1'b1, 12'h900, 1'b1, 12'h900);
        step3(1'b0, 12'h000, 1'b1, 12'h899);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
